// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and helpers for the matrix operand loader.
//   ELEM_W   element width (signed byte)
//   DIM      maximum matrix dimension; buses hold DIM*DIM elements
//   BUS_W    packed bus width
//   state_t  loader FSM states
package matrix_pkg;
  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned DIM      = 5;
  localparam int unsigned SLOTS    = DIM * DIM;
  localparam int unsigned BUS_W    = SLOTS * ELEM_W;
  localparam int unsigned MIN_SIZE = 2;
  localparam int unsigned MAX_SIZE = 5;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SLOT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_DONE
  } state_t;

  // Slots are laid out on the full DIM pitch, so smaller matrices leave gaps.
  function automatic logic [SLOT_W-1:0] slot_index(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
    return SLOT_W'(row) * SLOT_W'(DIM) + SLOT_W'(col);
  endfunction

  function automatic logic size_ok(input logic [IDX_W-1:0] n);
    return (n >= IDX_W'(MIN_SIZE)) && (n <= IDX_W'(MAX_SIZE));
  endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker for an N x N row-major element stream.
//   clk, rst  clock, async active-high reset
//   clr       return to (0,0)
//   en        advance one element
//   n         matrix dimension N
//   row, col  current element position
//   last      current position is (N-1, N-1)
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W-1:0] n,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);
  logic [IDX_W-1:0] n_m1;
  logic             col_end;

  assign n_m1    = n - IDX_W'(1);
  assign col_end = (col == n_m1);
  assign last    = col_end && (row == n_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/matrix_operand_loader.sv
// Byte-serial loader assembling two N x N signed-byte matrices (A then B)
// into packed DIM x DIM buses for the element-wise arithmetic stages.
//   clk, rst   clock, async active-high reset
//   start      begin a load (sampled in IDLE only), mat_size sampled with it
//   in_valid / in_ready / in_data   element stream, row-major, A first
//   matrix_A, matrix_B   packed buses, element (r,c) at [(r*DIM+c)*ELEM_W +: ELEM_W]
//   busy       high from accepted start through the load_done cycle
//   load_done  one-cycle pulse when both matrices are complete
//   size_err   one-cycle pulse after a start with mat_size outside 2..5
module matrix_operand_loader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        mat_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [BUS_W-1:0]  matrix_A,
  output logic [BUS_W-1:0]  matrix_B,
  output logic              busy,
  output logic              load_done,
  output logic              size_err
);
  state_t           state, state_nxt;
  logic [IDX_W-1:0] n_q;
  logic [IDX_W-1:0] row, col;
  logic             last;
  logic             accept;
  logic             xfer;
  logic [SLOT_W-1:0] slot;

  assign accept    = (state == ST_IDLE) && start && size_ok(mat_size);
  assign in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign load_done = (state == ST_DONE);
  assign slot      = slot_index(row, col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      n_q      <= '0;
      size_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      size_err <= (state == ST_IDLE) && start && !size_ok(mat_size);
      if (accept) n_q <= mat_size;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_LOAD_A;
      ST_LOAD_A: if (xfer && last) state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (xfer && last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The counter wraps to (0,0) on the last A element, so B restarts without an explicit clear.
  matrix_index_counter u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (xfer),
    .n    (n_q),
    .row  (row),
    .col  (col),
    .last (last)
  );

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic             hit;
    logic [ELEM_W-1:0] a_q, b_q;

    assign hit = xfer && (slot == SLOT_W'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else if (accept) begin
        a_q <= '0;
        b_q <= '0;
      end else if (hit) begin
        if (state == ST_LOAD_A) a_q <= in_data;
        if (state == ST_LOAD_B) b_q <= in_data;
      end
    end

    assign matrix_A[g*ELEM_W +: ELEM_W] = a_q;
    assign matrix_B[g*ELEM_W +: ELEM_W] = b_q;
  end
endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   mat_size;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [199:0] matrix_A, matrix_B;
  logic         busy, load_done, size_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic busy_at_done, rdy_at_done;

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_size  (mat_size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .matrix_A  (matrix_A),
    .matrix_B  (matrix_B),
    .busy      (busy),
    .load_done (load_done),
    .size_err  (size_err)
  );

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected bus for a stream of consecutive bytes starting at d0.
  function automatic logic [199:0] exp_bus(input int n, input logic [7:0] d0, input bit second);
    logic [199:0] b;
    int k;
    b = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        k = r * n + c + (second ? n * n : 0);
        b[(r * 5 + c) * 8 +: 8] = 8'(d0 + 8'(k));
      end
    return b;
  endfunction

  // Runs one load; done_cyc is the cycle (start cycle = 0) in which load_done is high.
  task automatic run_load(input int n, input logic [7:0] d0, input bit gaps, input bit restart_b,
                          output int xfers, output int dones, output int done_cyc);
    int edges;
    logic [7:0] d;
    bit xnow;
    xfers = 0; dones = 0; done_cyc = -1; d = d0; edges = 0;
    @(posedge clk); #1; start = 1'b1; mat_size = 3'(n);
    @(posedge clk); #1; start = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (load_done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = edges + 1;
          busy_at_done = busy;
          rdy_at_done = in_ready;
        end
      end
      if (done_cyc >= 0 && edges >= done_cyc + 3) break;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = d;
      start    = (restart_b && xfers == n * n + 1);
      xnow     = in_valid && in_ready;
      @(posedge clk); #1;
      edges++;
      if (xnow) begin
        xfers++;
        d = d + 8'd1;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int xf, dn, dc;
    logic [199:0] prev_a, prev_b;
    int bad_sizes[4] = '{0, 1, 6, 7};

    rst = 1'b1; start = 1'b0; mat_size = '0; in_valid = 1'b0; in_data = '0;
    #3;
    check("reset_A", matrix_A, '0);
    check("reset_B", matrix_B, '0);
    check("reset_ctl", {196'd0, in_ready, busy, load_done, size_err}, '0);
    @(posedge clk); #1; rst = 1'b0;

    // 5x5 gapless
    run_load(5, 8'd1, 1'b0, 1'b0, xf, dn, dc);
    check("t1_A", matrix_A, exp_bus(5, 8'd1, 1'b0));
    check("t1_B", matrix_B, exp_bus(5, 8'd1, 1'b1));
    check("t1_B_slot0", 200'(matrix_B[7:0]), 200'(8'd26));
    check("t1_done_cyc", 200'(dc), 200'(51));
    check("t1_xfers", 200'(xf), 200'(50));
    check("t1_dones", 200'(dn), 200'(1));
    check("t1_rdy_in_done", 200'(rdy_at_done), 200'(0));
    check("t1_busy_in_done", 200'(busy_at_done), 200'(1));
    check("t1_busy_after", 200'(busy), 200'(0));

    // 3x3 with negative bytes, gapped slot layout
    run_load(3, 8'h81, 1'b0, 1'b0, xf, dn, dc);
    check("t2_A", matrix_A, exp_bus(3, 8'h81, 1'b0));
    check("t2_B", matrix_B, exp_bus(3, 8'h81, 1'b1));
    check("t2_A00", 200'(matrix_A[7:0]), 200'(8'h81));
    check("t2_A10_slot5", 200'(matrix_A[47:40]), 200'(8'h84));
    check("t2_A_slot3", 200'(matrix_A[31:24]), 200'(0));
    check("t2_B_hi", 200'(matrix_B[199:104]), 200'(0));
    check("t2_done_cyc", 200'(dc), 200'(19));

    // 2x2 gapless then with random valid gaps
    run_load(2, 8'h10, 1'b0, 1'b0, xf, dn, dc);
    check("t3_ref_A", matrix_A, exp_bus(2, 8'h10, 1'b0));
    check("t3_ref_done_cyc", 200'(dc), 200'(9));
    run_load(2, 8'h10, 1'b1, 1'b0, xf, dn, dc);
    check("t3_gap_A", matrix_A, exp_bus(2, 8'h10, 1'b0));
    check("t3_gap_B", matrix_B, exp_bus(2, 8'h10, 1'b1));
    check("t3_gap_xfers", 200'(xf), 200'(8));
    check("t3_gap_dones", 200'(dn), 200'(1));

    // invalid sizes
    prev_a = exp_bus(2, 8'h10, 1'b0);
    prev_b = exp_bus(2, 8'h10, 1'b1);
    foreach (bad_sizes[i]) begin
      @(posedge clk); #1; start = 1'b1; mat_size = 3'(bad_sizes[i]);
      @(posedge clk); #1; start = 1'b0;
      check($sformatf("t4_err_%0d", bad_sizes[i]), 200'(size_err), 200'(1));
      check($sformatf("t4_busy_%0d", bad_sizes[i]), 200'(busy), 200'(0));
      @(posedge clk); #1;
      check($sformatf("t4_err_clr_%0d", bad_sizes[i]), 200'(size_err), 200'(0));
      check($sformatf("t4_A_%0d", bad_sizes[i]), matrix_A, prev_a);
      check($sformatf("t4_B_%0d", bad_sizes[i]), matrix_B, prev_b);
    end

    // reset mid-load
    @(posedge clk); #1; start = 1'b1; mat_size = 3'd5;
    @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    repeat (20) @(posedge clk);
    #1;
    check("t5_pre_A0", 200'(matrix_A[7:0]), 200'(8'h55));
    #2; rst = 1'b1; #1;
    check("t5_rst_A", matrix_A, '0);
    check("t5_rst_B", matrix_B, '0);
    check("t5_rst_ctl", {196'd0, in_ready, busy, load_done, size_err}, '0);
    in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    run_load(2, 8'hF0, 1'b0, 1'b0, xf, dn, dc);
    check("t5_A", matrix_A, exp_bus(2, 8'hF0, 1'b0));
    check("t5_B", matrix_B, exp_bus(2, 8'hF0, 1'b1));
    check("t5_done_cyc", 200'(dc), 200'(9));

    // start re-pulsed during LOAD_B
    run_load(3, 8'h20, 1'b0, 1'b1, xf, dn, dc);
    check("t6_dones", 200'(dn), 200'(1));
    check("t6_done_cyc", 200'(dc), 200'(19));
    check("t6_A", matrix_A, exp_bus(3, 8'h20, 1'b0));
    check("t6_B", matrix_B, exp_bus(3, 8'h20, 1'b1));
    check("t6_busy_after", 200'(busy), 200'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
